// File: rtl/imem_loader_if.sv
// imem_loader_if
// Groups the byte-stream handshake and the IMEM write port of the loader.
//   in_data   [7:0]  stream byte from the byte source
//   in_valid         in_data valid
//   in_ready         loader can take the byte this cycle
//   mem_addr  [15:0] IMEM write address
//   mem_wdata [15:0] IMEM write data
//   mem_wr           one-cycle IMEM write strobe
// Modport master is the loader side (it sinks the stream and masters the
// memory write port); modport slave is the surrounding system.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wr;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_addr,
        output mem_wdata,
        output mem_wr
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wr
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time instruction-memory writer. Parses a framed byte stream
//   0xA5, CNT_LO, CNT_HI, 2N data bytes (low byte first), CHK (XOR of data)
// and writes each assembled 16-bit word to IMEM. The core is held in reset
// until a frame finishes with a matching checksum.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (priority over restart)
//   restart    one-cycle pulse: abandon current state, start a new load
//   bus        imem_loader_if.master: stream in + IMEM write port out
//   core_rst_n active-low reset to the core, 1 only after a good load
//   done       load completed with good checksum (sticky)
//   err_code   00 none, 01 count overflow, 10 checksum mismatch (sticky)
module imem_loader #(
    parameter int          mem_size  = 64,
    parameter logic [15:0] base_addr = 16'h0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           restart,
    imem_loader_if.master  bus,
    output logic           core_rst_n,
    output logic           done,
    output logic [1:0]     err_code
);

    localparam logic [15:0] MEM_WORDS = 16'(mem_size);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] idx_reg, idx_next;
    logic [7:0]  acc_reg, acc_next;
    logic [7:0]  lo_reg, lo_next;
    logic [15:0] mem_addr_reg, mem_addr_next;
    logic [15:0] mem_wdata_reg, mem_wdata_next;
    logic        mem_wr_reg, mem_wr_next;
    logic        done_reg, done_next;
    logic        core_rst_n_reg, core_rst_n_next;
    logic [1:0]  err_reg, err_next;

    logic        in_ready;
    logic        accept;
    logic [15:0] frame_cnt;

    // Ready is a pure state decode, masked while rst or restart is high so
    // that no byte is consumed in a cycle that is about to be discarded.
    assign in_ready = !rst && !restart &&
                      (state_reg != S_DONE) && (state_reg != S_ERR);
    assign accept    = in_ready && bus.in_valid;
    assign frame_cnt = {bus.in_data, cnt_reg[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            acc_reg        <= '0;
            lo_reg         <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_wr_reg     <= 1'b0;
            done_reg       <= 1'b0;
            core_rst_n_reg <= 1'b0;
            err_reg        <= 2'b00;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            acc_reg        <= acc_next;
            lo_reg         <= lo_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_wr_reg     <= mem_wr_next;
            done_reg       <= done_next;
            core_rst_n_reg <= core_rst_n_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        acc_next        = acc_reg;
        lo_next         = lo_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_wr_next     = 1'b0;
        done_next       = done_reg;
        core_rst_n_next = core_rst_n_reg;
        err_next        = err_reg;

        if (restart) begin
            state_next      = S_IDLE;
            done_next       = 1'b0;
            core_rst_n_next = 1'b0;
            err_next        = 2'b00;
        end else if (accept) begin
            case (state_reg)
                S_IDLE: begin
                    // Anything other than the sync byte is silently dropped.
                    if (bus.in_data == SYNC_BYTE) begin
                        state_next = S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    cnt_next   = {8'h00, bus.in_data};
                    state_next = S_CNT_HI;
                end
                S_CNT_HI: begin
                    cnt_next = frame_cnt;
                    idx_next = '0;
                    acc_next = '0;
                    if (frame_cnt > MEM_WORDS) begin
                        state_next = S_ERR;
                        err_next   = 2'b01;
                    end else if (frame_cnt == 16'h0000) begin
                        state_next = S_CHK;
                    end else begin
                        state_next = S_DAT_LO;
                    end
                end
                S_DAT_LO: begin
                    lo_next    = bus.in_data;
                    acc_next   = acc_reg ^ bus.in_data;
                    state_next = S_DAT_HI;
                end
                S_DAT_HI: begin
                    acc_next       = acc_reg ^ bus.in_data;
                    mem_wr_next    = 1'b1;
                    mem_addr_next  = base_addr + idx_reg;
                    mem_wdata_next = {bus.in_data, lo_reg};
                    idx_next       = idx_reg + 16'd1;
                    // idx_reg < N-1, written without the N-1 underflow case.
                    if ((idx_reg + 16'd1) < cnt_reg) begin
                        state_next = S_DAT_LO;
                    end else begin
                        state_next = S_CHK;
                    end
                end
                S_CHK: begin
                    if (bus.in_data == acc_reg) begin
                        state_next      = S_DONE;
                        done_next       = 1'b1;
                        core_rst_n_next = 1'b1;
                    end else begin
                        state_next = S_ERR;
                        err_next   = 2'b10;
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_wr    = mem_wr_reg;
    assign core_rst_n    = core_rst_n_reg;
    assign done          = done_reg;
    assign err_code      = err_reg;

endmodule
